// File: rtl/euler_input_interpolator_pkg.sv
// Shared definitions for the Euler input interpolator: FSM encoding and the
// solver memory map slots used by the interpolation handshake.
package euler_input_interpolator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_RD    = 3'd1,
    ST_CFG_LATCH = 3'd2,
    ST_H_WR      = 3'd3,
    ST_EL        = 3'd4,
    ST_ADV       = 3'd5,
    ST_DONE      = 3'd6
  } interp_state_t;

  // Solver RAM map
  localparam int MM_M_ADD    = 1;     // input vector length m
  localparam int MM_U_ADD    = 5257;  // base of U(t) output vector
  localparam int MM_H_ADD    = 5457;  // step size output slot
  localparam int MM_HCFG_ADD = 5458;  // configured step size
  localparam int MM_UTAB_ADD = 5507;  // sampled input table base

endpackage

// File: rtl/add_sub_cla.sv
// Carry-lookahead style adder/subtractor; sub=1 computes a - b.
module add_sub_cla #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W-1:0] bx;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign bx = b ^ {W{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Carry chain from generate/propagate terms, carry-in is the subtract flag
  always_comb begin
    c    = '0;
    c[0] = sub;
    for (int k = 0; k < W; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
  end

  assign s  = p ^ c[W-1:0];
  assign co = c[W];

endmodule

// File: rtl/euler_input_interpolator_lerp_unit.sv
// Combinational linear interpolation: y = u0 + ((u1 - u0) * frac) >>> FRAC_BITS,
// all sums wrapping at W bits.
module lerp_unit #(
  parameter int W         = 16,
  parameter int FRAC_BITS = 4
) (
  input  logic signed [W-1:0]   u0,
  input  logic signed [W-1:0]   u1,
  input  logic [FRAC_BITS-1:0]  frac,
  output logic signed [W-1:0]   y
);

  logic signed [W-1:0]   diff;
  logic signed [W-1:0]   scaled;
  logic [W-1:0]          frac_x;
  logic [2*W-1:0]        prod;
  logic                  unused_co_d;
  logic                  unused_co_s;

  // Arithmetic shift on the full product first, then keep the low W bits
  function automatic logic signed [W-1:0] shr_trunc(input logic [2*W-1:0] p);
    logic signed [2*W-1:0] s;
    s = $signed(p) >>> FRAC_BITS;
    return s[W-1:0];
  endfunction

  assign frac_x = {{(W-FRAC_BITS){1'b0}}, frac};

  add_sub_cla #(.W(W)) u_diff (
    .a   (u1),
    .b   (u0),
    .sub (1'b1),
    .s   (diff),
    .co  (unused_co_d)
  );

  multiplier_16bit #(.W(W)) u_mul (
    .a  (diff),
    .b  (frac_x),
    .tc (1'b1),
    .p  (prod)
  );

  assign scaled = shr_trunc(prod);

  add_sub_cla #(.W(W)) u_sum (
    .a   (u0),
    .b   (scaled),
    .sub (1'b0),
    .s   (y),
    .co  (unused_co_s)
  );

endmodule

// File: rtl/multiplier_16bit.sv
// WxW multiplier with a run-time two's-complement select; tc=0 is unsigned.
module multiplier_16bit #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           tc,
  output logic [2*W-1:0] p
);

  logic signed [W:0]     a_x;
  logic signed [W:0]     b_x;
  logic signed [2*W+1:0] full;
  logic [1:0]            unused_top;

  assign a_x        = {tc & a[W-1], a};
  assign b_x        = {tc & b[W-1], b};
  assign full       = a_x * b_x;
  assign p          = full[2*W-1:0];
  assign unused_top = full[2*W+1:2*W];

endmodule

// File: rtl/euler_input_interpolator.sv
// Responder for the solver interpolation request: writes h and U(t) into the
// solver RAM slots, advances the internal time and signals completion.
module euler_input_interpolator
  import euler_input_interpolator_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int CUR_DATA_WIDTH = 16,
  parameter int FRAC_BITS      = 4,
  parameter int NSAMP          = 32,
  parameter int M_ADD          = MM_M_ADD,
  parameter int HCFG_ADD       = MM_HCFG_ADD,
  parameter int U_ADD          = MM_U_ADD,
  parameter int H_ADD          = MM_H_ADD,
  parameter int UTAB_ADD       = MM_UTAB_ADD
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Interpolate_Enable,
  output logic                      Interpolate_DONE,
  output logic                      BUSY,
  input  logic [DATA_WIDTH-1:0]     RAM_DATA_RD1,
  input  logic [DATA_WIDTH-1:0]     RAM_DATA_RD2,
  output logic [ADDRESS_WIDTH-1:0]  RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0]  RAM_ADD_RD2,
  output logic [ADDRESS_WIDTH-1:0]  RAM_ADD_WR,
  output logic [DATA_WIDTH-1:0]     RAM_DATA_WR,
  output logic                      RAM_ENABLE_WR,
  output logic [CUR_DATA_WIDTH-1:0] T_CUR
);

  localparam int CW = CUR_DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] LAST_I = CW'(NSAMP - 1);

  interp_state_t state_q, state_d;

  logic [CW-1:0]        t_cur_q, t_cur_d;
  logic [CW-1:0]        m_q, m_d;
  logic [CW-1:0]        h_q, h_d;
  logic [CW-1:0]        j_q, j_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [AW-1:0]        row0_q, row0_d;
  logic [AW-1:0]        row1_q, row1_d;
  logic [AW-1:0]        rd1_q, rd1_d;
  logic [AW-1:0]        rd2_q, rd2_d;
  logic [AW-1:0]        wr_add_q, wr_add_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CW-1:0]        i_full;
  logic                 clamp;
  logic [CW-1:0]        i_sel;
  logic [FRAC_BITS-1:0] frac_sel;
  logic [2*CW-1:0]      row_prod;
  logic [AW-1:0]        row0_calc;
  logic [AW-1:0]        row1_calc;
  logic signed [CW-1:0] lerp_y;
  logic [AW-1:0]        j_next_a;
  logic                 aborting;
  logic                 unused_bits;

  function automatic logic [DATA_WIDTH-1:0] sext(input logic [CW-1:0] x);
    return {{(DATA_WIDTH-CW){x[CW-1]}}, x};
  endfunction

  // Table row selection from the current time, clamped to the last sample
  assign i_full   = t_cur_q >> FRAC_BITS;
  assign clamp    = (i_full >= LAST_I);
  assign i_sel    = clamp ? LAST_I : i_full;
  assign frac_sel = clamp ? '0 : t_cur_q[FRAC_BITS-1:0];

  // Row base = i * m; m comes straight off read port 1 in CFG_LATCH
  multiplier_16bit #(.W(CW)) u_row_mul (
    .a  (i_sel),
    .b  (RAM_DATA_RD1[CW-1:0]),
    .tc (1'b0),
    .p  (row_prod)
  );

  assign row0_calc = AW'(UTAB_ADD) + row_prod[AW-1:0];
  assign row1_calc = clamp ? row0_calc : (row0_calc + AW'(RAM_DATA_RD1[CW-1:0]));

  lerp_unit #(.W(CW), .FRAC_BITS(FRAC_BITS)) u_lerp (
    .u0   (RAM_DATA_RD1[CW-1:0]),
    .u1   (RAM_DATA_RD2[CW-1:0]),
    .frac (frac_q),
    .y    (lerp_y)
  );

  assign j_next_a = AW'(j_q) + AW'(1);
  assign aborting = !Interpolate_Enable &&
                    (state_q != ST_IDLE) && (state_q != ST_DONE);

  assign unused_bits = ^{RAM_DATA_RD1[DATA_WIDTH-1:CW], RAM_DATA_RD2[DATA_WIDTH-1:CW],
                         row_prod[2*CW-1:AW]};

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    t_cur_d   = t_cur_q;
    m_d       = m_q;
    h_d       = h_q;
    j_d       = j_q;
    frac_d    = frac_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE: begin
        if (Interpolate_Enable) begin
          rd1_d   = AW'(M_ADD);
          rd2_d   = AW'(HCFG_ADD);
          busy_d  = 1'b1;
          state_d = ST_CFG_RD;
        end else begin
          done_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      ST_CFG_RD: begin
        state_d = ST_CFG_LATCH;
      end
      ST_CFG_LATCH: begin
        m_d     = RAM_DATA_RD1[CW-1:0];
        h_d     = RAM_DATA_RD2[CW-1:0];
        frac_d  = frac_sel;
        row0_d  = row0_calc;
        row1_d  = row1_calc;
        state_d = ST_H_WR;
      end
      ST_H_WR: begin
        wr_add_d  = AW'(H_ADD);
        wr_data_d = sext(h_q);
        wr_en_d   = 1'b1;
        rd1_d     = row0_q;
        rd2_d     = row1_q;
        j_d       = '0;
        state_d   = (m_q == '0) ? ST_ADV : ST_EL;
      end
      ST_EL: begin
        wr_add_d  = AW'(U_ADD) + AW'(j_q);
        wr_data_d = sext(lerp_y);
        wr_en_d   = 1'b1;
        rd1_d     = row0_q + j_next_a;
        rd2_d     = row1_q + j_next_a;
        j_d       = j_q + ONE_C;
        if (j_q == (m_q - ONE_C)) begin
          state_d = ST_ADV;
        end
      end
      ST_ADV: begin
        t_cur_d = t_cur_q + h_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        if (Interpolate_Enable) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (aborting) begin
      state_d = ST_IDLE;
      t_cur_d = t_cur_q;
      wr_en_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers, updated on the falling clock edge
  always_ff @(negedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      t_cur_q   <= '0;
      m_q       <= '0;
      h_q       <= '0;
      j_q       <= '0;
      frac_q    <= '0;
      row0_q    <= '0;
      row1_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_cur_q   <= t_cur_d;
      m_q       <= m_d;
      h_q       <= h_d;
      j_q       <= j_d;
      frac_q    <= frac_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Interpolate_DONE = done_q;
  assign BUSY             = busy_q;
  assign RAM_ADD_RD1      = rd1_q;
  assign RAM_ADD_RD2      = rd2_q;
  assign RAM_ADD_WR       = wr_add_q;
  assign RAM_DATA_WR      = wr_data_q;
  assign RAM_ENABLE_WR    = wr_en_q;
  assign T_CUR            = t_cur_q;

endmodule

// File: tb/tb_euler_input_interpolator.sv
// Directed bench for euler_input_interpolator with a behavioural shared RAM.
module tb_euler_input_interpolator;

  localparam int A_M    = 1;
  localparam int A_HCFG = 5458;
  localparam int A_U    = 5257;
  localparam int A_H    = 5457;
  localparam int A_TAB  = 5507;

  logic        CLK;
  logic        RST;
  logic        Interpolate_Enable;
  logic        Interpolate_DONE;
  logic        BUSY;
  logic [63:0] RAM_DATA_RD1;
  logic [63:0] RAM_DATA_RD2;
  logic [12:0] RAM_ADD_RD1;
  logic [12:0] RAM_ADD_RD2;
  logic [12:0] RAM_ADD_WR;
  logic [63:0] RAM_DATA_WR;
  logic        RAM_ENABLE_WR;
  logic [15:0] T_CUR;

  logic [63:0] mem [0:8191];
  int          log_add [0:255];
  longint      log_dat [0:255];
  int          log_n = 0;
  int          total = 0;
  int          bad   = 0;

  euler_input_interpolator dut (
    .CLK                (CLK),
    .RST                (RST),
    .Interpolate_Enable (Interpolate_Enable),
    .Interpolate_DONE   (Interpolate_DONE),
    .BUSY               (BUSY),
    .RAM_DATA_RD1       (RAM_DATA_RD1),
    .RAM_DATA_RD2       (RAM_DATA_RD2),
    .RAM_ADD_RD1        (RAM_ADD_RD1),
    .RAM_ADD_RD2        (RAM_ADD_RD2),
    .RAM_ADD_WR         (RAM_ADD_WR),
    .RAM_DATA_WR        (RAM_DATA_WR),
    .RAM_ENABLE_WR      (RAM_ENABLE_WR),
    .T_CUR              (T_CUR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign RAM_DATA_RD1 = mem[RAM_ADD_RD1];
  assign RAM_DATA_RD2 = mem[RAM_ADD_RD2];

  // Record every write strobe the RAM sees
  always @(negedge CLK) begin
    if (RAM_ENABLE_WR && log_n < 256) begin
      log_add[log_n] = int'(RAM_ADD_WR);
      log_dat[log_n] = longint'(RAM_DATA_WR);
      log_n = log_n + 1;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int add, input longint dat);
    chk({tag, "_addr"}, longint'(log_add[idx]), longint'(add));
    chk({tag, "_data"}, log_dat[idx], dat);
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic setw(input int a, input int v);
    mem[a] = 64'(longint'(v));
  endtask

  // Raise the request and return the edge index at which DONE is first seen
  task automatic request(output int done_e);
    done_e = -1;
    Interpolate_Enable = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (Interpolate_DONE) begin
        done_e = e;
        break;
      end
    end
  endtask

  task automatic release_req(input string tag);
    Interpolate_Enable = 1'b0;
    tick();
    chk({tag, "_done_low"}, longint'(Interpolate_DONE), 0);
    tick();
  endtask

  initial begin
    int de;
    int n0;
    RST = 1'b0;
    Interpolate_Enable = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = '0;

    repeat (3) tick();
    chk("rst_done", longint'(Interpolate_DONE), 0);
    chk("rst_busy", longint'(BUSY), 0);
    chk("rst_wen", longint'(RAM_ENABLE_WR), 0);
    chk("rst_tcur", longint'(T_CUR), 0);
    chk("rst_rd1", longint'(RAM_ADD_RD1), 0);
    chk("rst_wdata", longint'(RAM_DATA_WR), 0);
    RST = 1'b1;
    tick();

    // First request: T=0, m=2, h=8
    setw(A_M, 2); setw(A_HCFG, 8);
    setw(A_TAB + 0, 10); setw(A_TAB + 1, -4);
    setw(A_TAB + 2, 26); setw(A_TAB + 3, 12);
    n0 = log_n;
    request(de);
    chk("r1_done_edge", de, 7);
    chk("r1_busy", longint'(BUSY), 0);
    chk("r1_nwr", log_n - n0, 3);
    chk_wr("r1_h", n0, A_H, 8);
    chk_wr("r1_u0", n0 + 1, A_U, 10);
    chk_wr("r1_u1", n0 + 2, A_U + 1, -4);
    chk("r1_tcur", longint'(T_CUR), 8);
    release_req("r1");

    // Second request: frac = 8/16
    n0 = log_n;
    request(de);
    chk("r2_done_edge", de, 7);
    chk("r2_nwr", log_n - n0, 3);
    chk_wr("r2_u0", n0 + 1, A_U, 18);
    chk_wr("r2_u1", n0 + 2, A_U + 1, 4);
    chk("r2_tcur", longint'(T_CUR), 16);
    release_req("r2");

    // m=0, large step to reach the end of the table
    setw(A_M, 0); setw(A_HCFG, 485);
    n0 = log_n;
    request(de);
    chk("m0_done_edge", de, 5);
    chk("m0_nwr", log_n - n0, 1);
    chk_wr("m0_h", n0, A_H, 485);
    chk("m0_tcur", longint'(T_CUR), 501);
    release_req("m0");

    // Clamp: T = 31*16+5, row 31 returned as-is
    setw(A_M, 2); setw(A_HCFG, 8);
    setw(A_TAB + 62, 77); setw(A_TAB + 63, -300);
    setw(A_TAB + 64, 1000); setw(A_TAB + 65, 1000);
    n0 = log_n;
    request(de);
    chk("cl_done_edge", de, 7);
    chk_wr("cl_u0", n0 + 1, A_U, 77);
    chk_wr("cl_u1", n0 + 2, A_U + 1, -300);
    chk("cl_tcur", longint'(T_CUR), 509);
    release_req("cl");

    // Reset mid-life returns time to zero
    RST = 1'b0;
    tick(); tick();
    chk("rst2_tcur", longint'(T_CUR), 0);
    RST = 1'b1;
    tick();

    // Move time to 12 with an m=0 request
    setw(A_M, 0); setw(A_HCFG, 12);
    request(de);
    chk("t12_tcur", longint'(T_CUR), 12);
    release_req("t12");

    // Negative slope: U0=100, U1=-28, frac=12 -> 4, then hold DONE
    setw(A_M, 1); setw(A_HCFG, 4);
    setw(A_TAB + 0, 100); setw(A_TAB + 1, -28);
    n0 = log_n;
    request(de);
    chk("ns_done_edge", de, 6);
    chk("ns_nwr", log_n - n0, 2);
    chk_wr("ns_u0", n0 + 1, A_U, 4);
    chk("ns_tcur", longint'(T_CUR), 16);
    n0 = log_n;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_done", longint'(Interpolate_DONE), 1);
    end
    chk("hold_nwr", log_n - n0, 0);
    chk("hold_busy", longint'(BUSY), 0);
    release_req("ns");

    // Abort after edge 4 with m=4
    setw(A_M, 4); setw(A_HCFG, 8);
    setw(A_TAB + 4, 55);
    setw(A_U + 1, 0); setw(A_U + 2, 0);
    n0 = log_n;
    Interpolate_Enable = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    chk("ab_busy_e4", longint'(BUSY), 1);
    Interpolate_Enable = 1'b0;
    tick();
    chk("ab_busy_e5", longint'(BUSY), 0);
    de = 0;
    for (int k = 0; k < 6; k++) begin
      if (Interpolate_DONE) de = 1;
      tick();
    end
    chk("ab_done_seen", de, 0);
    chk("ab_nwr", log_n - n0, 2);
    chk_wr("ab_h", n0, A_H, 8);
    chk_wr("ab_u0", n0 + 1, A_U, 55);
    chk("ab_tcur", longint'(T_CUR), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/euler_input_interpolator.md
# euler_input_interpolator

Responder side of the solver's interpolation handshake. On each `Interpolate_Enable` request from the Euler controller it produces the current step size `h` and the input vector `U(t)` for the current time point. `U(t)` is a linear interpolation between two consecutive rows of a sampled input table held in the shared data RAM. The block writes both results back into the solver's fixed RAM slots, advances its internal time, and raises `Interpolate_DONE`. It drives the shared RAM port set while `BUSY` is high; the top level muxes the RAM ports on `BUSY`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 13: RAM address width.
- `DATA_WIDTH`, default 64: RAM word width.
- `CUR_DATA_WIDTH`, default 16: arithmetic width; the low bits of each RAM word are used.
- `FRAC_BITS`, default 4: fractional bits of the time register; samples are spaced one time unit apart.
- `NSAMP`, default 32: number of rows in the input table.
- `M_ADD`, default 1: RAM slot holding `m`, the input vector length.
- `HCFG_ADD`, default 5458: RAM slot holding the configured step `h`, in time units at `FRAC_BITS` resolution.
- `U_ADD`, default 5257: base of the `U(t)` output vector.
- `H_ADD`, default 5457: output slot for `h`.
- `UTAB_ADD`, default 5507: table base; row `i`, element `j` is at `UTAB_ADD + i*m + j`.

Ports:
- `CLK` in, 1: clock. All state changes on `negedge CLK`.
- `RST` in, 1: synchronous, active-low reset.
- `Interpolate_Enable` in, 1: request, level-held by the controller.
- `Interpolate_DONE` out, 1: results written; held high while `Interpolate_Enable` is high.
- `BUSY` out, 1: the block owns the RAM ports.
- `RAM_DATA_RD1` in, `DATA_WIDTH`: read data, port 1.
- `RAM_DATA_RD2` in, `DATA_WIDTH`: read data, port 2.
- `RAM_ADD_RD1` out, `ADDRESS_WIDTH`: read address, port 1.
- `RAM_ADD_RD2` out, `ADDRESS_WIDTH`: read address, port 2.
- `RAM_ADD_WR` out, `ADDRESS_WIDTH`: write address.
- `RAM_DATA_WR` out, `DATA_WIDTH`: write data, sign-extended from `CUR_DATA_WIDTH`.
- `RAM_ENABLE_WR` out, 1: write strobe, one cycle per word.
- `T_CUR` out, `CUR_DATA_WIDTH`: current time register, unsigned, `FRAC_BITS` fractional bits.

## Operation
- Reset (`RST`=0): every output and internal register is 0, and the state is IDLE.
- RAM read latency is one edge: an address driven at edge n is sampled at edge n+1.
- IDLE
  - On `Interpolate_Enable`=1: drive RD1=`M_ADD`, RD2=`HCFG_ADD`, set `BUSY`, go to CFG_RD.
  - Otherwise `Interpolate_DONE`=0 and `BUSY`=0.
- CFG_RD: wait one edge, then go to CFG_LATCH.
- CFG_LATCH
  - Latch `m` and `h` from the low 16 bits of RD1 and RD2.
  - `i = T_CUR >> FRAC_BITS`; `frac = T_CUR[FRAC_BITS-1:0]`.
  - If `i >= NSAMP-1`, clamp: `i = NSAMP-1`, `frac = 0`.
  - `row0 = UTAB_ADD + i*m` via the multiplier. `row1 = row0 + m`, or `row0` when clamped.
- H_WR
  - Write `h` to `H_ADD`.
  - Issue RD1=`row0+0`, RD2=`row1+0`, set `j`=0.
  - If `m`=0, go to ADV; otherwise go to EL.
- EL (one element per edge)
  - `U(t)[j] = U0 + ((U1 - U0) * frac) >>> FRAC_BITS`, where `U0` is from RD1 and `U1` is from RD2.
  - Subtraction, add and truncation wrap at 16 bits. The 16x16 product is 32-bit signed; the arithmetic shift is applied before truncation.
  - Write the result to `U_ADD + j`, issue reads for `j+1`, increment `j`.
  - After `j = m-1` is written, go to ADV.
- ADV: `T_CUR += h`, 16-bit wrap. Go to DONE.
- DONE
  - `Interpolate_DONE`=1, `BUSY`=0, `RAM_ENABLE_WR`=0.
  - When `Interpolate_Enable` drops: go to IDLE, and `Interpolate_DONE`=0 from the same edge.
- `Interpolate_Enable` drops in any state other than IDLE or DONE: abort to IDLE. `T_CUR` is unchanged, no further writes are made, and words already written are left as they are.
- `RST` low mid-operation: immediate return to the reset state, `T_CUR`=0.
- `h`=0: `T_CUR` does not advance, so repeated requests give identical outputs.

## Timing
- Edge 0 is the first edge at which IDLE sees `Interpolate_Enable`=1.
- `h` is written at edge 3.
- `U[j]` is written at edge 4+j.
- `T_CUR` updates at edge 4+m.
- `Interpolate_DONE` rises at edge 5+m. This also holds for `m`=0.
- `RAM_ENABLE_WR` is asserted on exactly m+1 edges per request.
- A new request is accepted no earlier than one edge after the return to IDLE.

## Structure
- Shared package holds:
  - the state encoding: IDLE, CFG_RD, CFG_LATCH, H_WR, EL, ADV, DONE;
  - the solver memory-map constants (`M_ADD`, `H_ADD`, `U_ADD`, `HCFG_ADD`, `UTAB_ADD`).
- One sub-module, `lerp_unit`: combinational `U0`, `U1`, `frac` to result. It uses the existing `add_sub_cla` and `multiplier_16bit` blocks.
- Row base multiply: a separate `multiplier_16bit` instance.

## Test plan
- Reset and first request:
  - Stimulus: `RST` low then high; `m`=2, `h`=8; row0={10,-4}, row1={26,12}; assert Enable.
  - Response: writes `H_ADD`=8, `U_ADD`=10, `U_ADD+1`=-4; `T_CUR`=8; DONE at edge 7.
- Second request:
  - Response: `U`={18,4}, `T_CUR`=16.
- Clamp at end of table:
  - Stimulus: `T_CUR` driven to `(NSAMP-1)<<4`+5.
  - Response: row 31 is returned unchanged, with `frac` forced to 0.
- `m`=0:
  - Response: only the `H_ADD` write; DONE at edge 5; `T_CUR` advances.
- Abort:
  - Stimulus: Enable dropped at edge 4 with `m`=4.
  - Response: only `h` and `U[0]` are written, `T_CUR` is unchanged, IDLE next edge, DONE never rises.
- Negative slope and DONE hold:
  - Stimulus: `U0`=100, `U1`=-28, `frac`=12.
  - Response: `U`=4.
  - Stimulus: Enable held 5 extra edges after DONE.
  - Response: DONE stays high and no writes occur.
